csa42_accumulator: RTL and testbench

CSA42_ACCUMULATOR -- requirements
Module: csa42_accumulator

---
 rtl/csa42_accumulator.sv | 138 +++++++++++++
 tb/tb_csa42_accumulator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/csa42_accumulator.sv
// Accumulates groups of unsigned operand pairs in carry-save form through a 4:2 compressor row,
// then converts the redundant total to binary one CHUNK per cycle before presenting it.
module csa42_accumulator #(
    parameter int unsigned W     = 16,
    parameter int unsigned G     = 4,
    parameter int unsigned CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_a,
    input  logic [W-1:0]        in_b,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W+G-1:0]      out_sum,
    output logic [7:0]          out_beats
);
    localparam int unsigned AW  = W + G;
    localparam int unsigned K   = AW / CHUNK;
    localparam int unsigned IW  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CW1 = CHUNK + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] CONV = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [AW-1:0]  r_s;
    logic [AW-1:0]  r_c;
    logic [AW-1:0]  r_sum;
    logic [7:0]     r_cnt;
    logic [IW-1:0]  r_idx;
    logic           r_carry;
    logic           r_in_ready;
    logic           r_out_valid;

    logic           w_acc;
    logic [AW-1:0]  w_a;
    logic [AW-1:0]  w_b;
    logic [AW-1:0]  w_s1;
    logic [AW-2:0]  w_cout;
    logic [AW-1:0]  w_cin;
    logic [AW-2:0]  w_cy;
    logic [AW-1:0]  w_s_nxt;
    logic [AW-1:0]  w_c_nxt;
    int unsigned    w_base;
    logic [CW1-1:0] w_chunk;

    assign w_acc = in_valid && r_in_ready;
    assign w_a   = AW'(in_a);
    assign w_b   = AW'(in_b);

    // 4:2 row: first full adder's cout ripples only one bit, so the row has no carry chain
    assign w_s1    = r_s ^ r_c ^ w_a;
    assign w_cout  = (r_s[AW-2:0] & r_c[AW-2:0]) | (r_s[AW-2:0] & w_a[AW-2:0])
                   | (r_c[AW-2:0] & w_a[AW-2:0]);
    assign w_cin   = {w_cout, 1'b0};
    assign w_s_nxt = w_s1 ^ w_b ^ w_cin;
    assign w_cy    = (w_s1[AW-2:0] & w_b[AW-2:0]) | (w_s1[AW-2:0] & w_cin[AW-2:0])
                   | (w_b[AW-2:0] & w_cin[AW-2:0]);
    assign w_c_nxt = {w_cy, 1'b0};

    assign w_base  = 32'(r_idx) * CHUNK;
    assign w_chunk = CW1'(r_s[w_base +: CHUNK]) + CW1'(r_c[w_base +: CHUNK]) + CW1'(r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ACC: begin
                if (w_acc) begin
                    w_state_nxt = in_last ? CONV : ACC;
                end
            end
            CONV: begin
                if (r_idx == IW'(K - 1)) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s         <= '0;
            r_c         <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE) || (w_state_nxt == ACC);
            r_out_valid <= (w_state_nxt == HOLD);
            if (w_acc) begin
                r_s     <= w_s_nxt;
                r_c     <= w_c_nxt;
                r_cnt   <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
                r_idx   <= '0;
                r_carry <= 1'b0;
            end
            if (r_state == CONV) begin
                r_sum[w_base +: CHUNK] <= w_chunk[CHUNK-1:0];
                r_carry                <= w_chunk[CHUNK];
                r_idx                  <= r_idx + IW'(1);
            end
            if (r_state == HOLD && out_ready) begin
                r_s   <= '0;
                r_c   <= '0;
                r_cnt <= '0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_beats = r_cnt;
endmodule

// File: tb/tb_csa42_accumulator.sv
// Directed bench for csa42_accumulator: table of uniform groups plus hand-written
// sequences for backpressure, gapped input and reset during conversion.
module tb_csa42_accumulator;
    localparam int unsigned W  = 16;
    localparam int unsigned AW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [7:0]    out_beats;

    int checks = 0;
    int errors = 0;

    csa42_accumulator #(.W(16), .G(4), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            nbeats;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] exp_sum;
        logic [7:0]    exp_beats;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the beat is presented across the next posedge
    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for out_valid (bounded), check latency and result
    task automatic wait_result(input string name, input logic [AW-1:0] es, input logic [7:0] eb);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'd5);
        chk({name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({name, " in_ready"}, 32'(in_ready), 32'd0);
        chk({name, " out_sum"}, 32'(out_sum), 32'(es));
        chk({name, " out_beats"}, 32'(out_beats), 32'(eb));
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " drain out_valid"}, 32'(out_valid), 32'd0);
        chk({name, " drain in_ready"}, 32'(in_ready), 32'd1);
        chk({name, " drain out_beats"}, 32'(out_beats), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1,   16'h0003, 16'h0005, 20'h00008, 8'd1};
        vecs[1] = '{4,   16'hFFFF, 16'hFFFF, 20'h7FFF8, 8'd4};
        vecs[2] = '{16,  16'hFFFF, 16'hFFFF, 20'hFFFE0, 8'd16};
        vecs[3] = '{3,   16'h1234, 16'h4321, 20'h0FFFF, 8'd3};
        vecs[4] = '{1,   16'hFFFF, 16'hFFFF, 20'h1FFFE, 8'd1};
        vecs[5] = '{1,   16'h0000, 16'h0000, 20'h00000, 8'd1};
        vecs[6] = '{300, 16'h0001, 16'h0000, 20'h0012C, 8'd255};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_sum", 32'(out_sum), 32'd0);
        chk("reset out_beats", 32'(out_beats), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            for (int k = 0; k < vecs[v].nbeats; k++) begin
                beat(vecs[v].a, vecs[v].b, (k == vecs[v].nbeats - 1));
            end
            wait_result(nm, vecs[v].exp_sum, vecs[v].exp_beats);
            drain(nm);
        end

        // Gapped input: ACC must hold through idle cycles
        beat(16'd1, 16'd2, 1'b0);
        repeat (3) @(negedge clk);
        chk("gap in_ready", 32'(in_ready), 32'd1);
        chk("gap out_beats", 32'(out_beats), 32'd1);
        beat(16'd10, 16'd20, 1'b1);
        wait_result("gap", 20'h00021, 8'd2);
        drain("gap");

        // Backpressure in HOLD with in_valid pulses that must be ignored
        beat(16'd7, 16'd9, 1'b1);
        wait_result("bp", 20'h00010, 8'd1);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_a     = 16'hAAAA;
            in_b     = 16'h5555;
            in_last  = 1'b1;
            @(negedge clk);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp out_sum", 32'(out_sum), 32'h10);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("bp");
        beat(16'd2, 16'd2, 1'b1);
        wait_result("bp next", 20'h00004, 8'd1);
        drain("bp next");

        // Reset asserted mid-conversion abandons the group
        beat(16'd5, 16'd6, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("conv in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async out_valid", 32'(out_valid), 32'd0);
        chk("rst async out_sum", 32'(out_sum), 32'd0);
        chk("rst async out_beats", 32'(out_beats), 32'd0);
        chk("rst async in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst release in_ready", 32'(in_ready), 32'd1);
        chk("rst release out_valid", 32'(out_valid), 32'd0);
        beat(16'd1, 16'd1, 1'b1);
        wait_result("after rst", 20'h00002, 8'd1);
        drain("after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
